// File: rtl/spw_arb_pkg.sv
// spw_arb_pkg: shared types and character constants for the SpaceWire TX packet arbiter.
package spw_arb_pkg;
  typedef enum logic [1:0] {IDLE, XFER, EEP_INS, FLUSH} arb_state_t;
  localparam logic [8:0] SPW_EOP  = 9'h100;
  localparam logic [8:0] SPW_EEP  = 9'h101;
  localparam logic [2:0] LINK_RUN = 3'd5;
  function automatic logic is_marker(input logic [8:0] c);
    return |(c & SPW_EOP);
  endfunction
endpackage

// File: rtl/spw_rr_pick.sv
// spw_rr_pick: combinational round-robin picker, first request strictly after ptr (wrapping).
module spw_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
    grant = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/spw_tx_packet_arbiter.sv
// spw_tx_packet_arbiter: grants whole packets from N sources onto one SpaceWire TX FIFO port,
// inserting EEP on stalled packets and discarding packet tails cut by link loss.
module spw_tx_packet_arbiter
  import spw_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               CLOCK,
  input  logic               RESETn,
  input  logic [2:0]         LINK_STATE,
  input  logic               TX_FULL,
  output logic [8:0]         DATA_I,
  output logic               WR_DATA,
  input  logic [N_REQ-1:0]   REQ_VALID,
  input  logic [9*N_REQ-1:0] REQ_DATA,
  output logic [N_REQ-1:0]   REQ_READY,
  output logic [N_REQ-1:0]   GRANT,
  output logic               TIMEOUT_EVT,
  output logic               FLUSH_EVT
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d, pick_grant;
  logic [IW-1:0]    ptr_q, ptr_d, pick_idx;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [8:0]       chars [N_REQ];
  logic [8:0]       g_data;
  logic             pick_any, run, g_valid, xfer_rdy, xfer, eep_wr;
  for (genvar i = 0; i < N_REQ; i++) begin : g_chars
    assign chars[i] = REQ_DATA[9*i +: 9];
  end
  spw_rr_pick #(.N(N_REQ)) u_pick (
    .req  (REQ_VALID),
    .ptr  (ptr_q),
    .grant(pick_grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );
  // ptr_q always holds the index of the current owner while a grant is active
  always_comb begin
    run         = LINK_STATE == LINK_RUN;
    g_valid     = REQ_VALID[ptr_q];
    g_data      = chars[ptr_q];
    xfer_rdy    = state_q == XFER && run && !TX_FULL;
    xfer        = xfer_rdy && g_valid;
    eep_wr      = state_q == EEP_INS && run && !TX_FULL;
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    REQ_READY   = (xfer_rdy ? grant_q : '0) | (state_q == FLUSH ? grant_q & REQ_VALID : '0);
    WR_DATA     = xfer || eep_wr;
    DATA_I      = xfer ? g_data : eep_wr ? SPW_EEP : '0;
    TIMEOUT_EVT = eep_wr;
    FLUSH_EVT   = state_q == XFER && !run;
    GRANT       = grant_q;
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (run && pick_any) begin
        state_d = XFER;
        grant_d = pick_grant;
        ptr_d   = pick_idx;
        cnt_d   = '0;
      end
      XFER: if (!run) state_d = FLUSH;
      else if (xfer) begin
        cnt_d = '0;
        if (is_marker(g_data)) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end else if (!g_valid) begin
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == CNT_MAX) ? EEP_INS : XFER;
      end
      EEP_INS: if (!run || !TX_FULL) begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
      FLUSH: if (g_valid) begin
        cnt_d = '0;
        if (is_marker(g_data)) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end else if (cnt_inc == CNT_MAX) begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end else cnt_d = cnt_inc;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_spw_tx_packet_arbiter.sv
// tb_spw_tx_packet_arbiter: directed scenarios plus random traffic against a packet-level reference.
module tb_spw_tx_packet_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;
  logic           clk = 1'b0;
  logic           rst_n;
  logic [2:0]     link;
  logic           full;
  logic [8:0]     data_i;
  logic           wr;
  logic [N-1:0]   valid, ready, grant, en;
  logic [9*N-1:0] rdata;
  logic           tevt, fevt;
  always #5 clk = ~clk;
  spw_tx_packet_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .CLOCK(clk), .RESETn(rst_n), .LINK_STATE(link), .TX_FULL(full),
    .DATA_I(data_i), .WR_DATA(wr), .REQ_VALID(valid), .REQ_DATA(rdata),
    .REQ_READY(ready), .GRANT(grant), .TIMEOUT_EVT(tevt), .FLUSH_EVT(fevt)
  );
  int checks = 0, errors = 0;
  logic [8:0] srcq [N][$];
  logic [8:0] fifo [$];
  int gseq [$];
  logic [N-1:0] prev_grant;
  int n_tevt, n_fevt, n_disc;
  // reference: owner (-1 none), last winner, phase 0 wait/1 send/2 terminate/3 drain, idle count
  int owner, last, phase, idle;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      valid[i]        = en[i] && srcq[i].size() > 0;
      rdata[9*i +: 9] = srcq[i].size() > 0 ? srcq[i][0] : 9'h0;
    end
  endtask
  task automatic cyc();
    logic [N-1:0] e_rdy, e_grant, fire;
    logic [8:0] e_d, head;
    logic [1:0] o, j;
    logic e_wr, e_t, e_f;
    bit run;
    int n_ph, n_ow, n_last, n_idle;
    drive();
    @(negedge clk);
    o = 2'(owner < 0 ? 0 : owner);
    head = srcq[o].size() > 0 ? srcq[o][0] : 9'h0;
    run = link == 3'd5;
    e_rdy = '0; e_wr = 0; e_d = '0; e_t = 0; e_f = 0;
    e_grant = (!rst_n || owner < 0) ? '0 : (4'(1) << o);
    n_ph = phase; n_ow = owner; n_last = last; n_idle = idle;
    if (!rst_n) begin
      n_ph = 0; n_ow = -1; n_last = N - 1; n_idle = 0;
    end else case (phase)
      0: if (run) for (int k = 1; k <= N; k++) begin
        j = 2'((last + k) % N);
        if (valid[j] && n_ow < 0) begin
          n_ow = int'(j); n_last = int'(j); n_ph = 1; n_idle = 0;
        end
      end
      1: begin
        e_rdy = (run && !full) ? e_grant : '0;
        if (!run) begin
          e_f = 1; n_ph = 3;
        end else if (!full && valid[o]) begin
          e_wr = 1; e_d = head; n_idle = 0;
          if (head[8]) begin n_ph = 0; n_ow = -1; end
        end else if (!valid[o]) begin
          n_idle = idle + 1;
          if (n_idle == TO - 1) n_ph = 2;
        end
      end
      2: if (!run || !full) begin
        e_wr = run; e_d = run ? 9'h101 : 9'h0; e_t = run;
        n_ph = 0; n_ow = -1; n_idle = 0;
      end
      default: begin
        e_rdy = e_grant & valid;
        if (valid[o]) begin
          n_idle = 0;
          if (head[8]) begin n_ph = 0; n_ow = -1; end
        end else begin
          n_idle = idle + 1;
          if (n_idle == TO - 1) begin n_ph = 0; n_ow = -1; n_idle = 0; end
        end
      end
    endcase
    chk("GRANT", 32'(grant), 32'(e_grant));
    chk("REQ_READY", 32'(ready), 32'(e_rdy));
    chk("WR_DATA", 32'(wr), 32'(e_wr));
    chk("DATA_I", 32'(data_i), 32'(e_d));
    chk("TIMEOUT_EVT", 32'(tevt), 32'(e_t));
    chk("FLUSH_EVT", 32'(fevt), 32'(e_f));
    fire = valid & ready;
    if (wr) fifo.push_back(data_i);
    if (tevt) n_tevt++;
    if (fevt) n_fevt++;
    if (phase == 3 && fire != 0) n_disc++;
    if (grant != 0 && grant != prev_grant)
      for (int i = 0; i < N; i++) if (grant[i]) gseq.push_back(i);
    prev_grant = grant;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    phase = n_ph; owner = n_ow; last = n_last; idle = n_idle;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    cyc();
    rst_n = 1'b1;
  endtask
  initial begin
    logic [8:0] t1e [8] = '{9'h001, 9'h002, 9'h003, 9'h100, 9'h011, 9'h012, 9'h013, 9'h100};
    logic [8:0] t3e [6] = '{9'h021, 9'h022, 9'h023, 9'h024, 9'h025, 9'h100};
    int len;
    rst_n = 1'b0; link = 3'd5; full = 1'b0; en = '1; prev_grant = '0;
    owner = -1; last = N - 1; phase = 0; idle = 0;
    n_tevt = 0; n_fevt = 0; n_disc = 0;
    drive();
    #2;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_wr", 32'(wr), 0);
    do_reset();
    // two interleaving-prone packets
    srcq[0] = '{9'h001, 9'h002, 9'h003, 9'h100};
    srcq[2] = '{9'h011, 9'h012, 9'h013, 9'h100};
    fifo.delete(); gseq.delete();
    repeat (14) cyc();
    chk("t1_len", 32'(fifo.size()), 8);
    for (int i = 0; i < 8; i++) chk("t1_data", 32'(fifo[i]), 32'(t1e[i]));
    chk("t1_order", 32'(gseq.size() == 2 && gseq[0] == 0 && gseq[1] == 2), 1);
    // round-robin fairness with one-character packets
    do_reset();
    for (int i = 0; i < N; i++) srcq[i] = '{9'h100, 9'h100, 9'h100};
    gseq.delete();
    repeat (12) cyc();
    chk("t2_count", 32'(gseq.size() >= 5), 1);
    for (int i = 0; i < 5; i++) chk("t2_seq", 32'(gseq[i]), 32'(i % N));
    repeat (20) cyc();
    // long backpressure mid-packet
    srcq[0] = '{9'h021, 9'h022, 9'h023, 9'h024, 9'h025, 9'h100};
    fifo.delete(); n_tevt = 0;
    repeat (3) cyc();
    full = 1'b1;
    repeat (50) cyc();
    chk("t3_stall", 32'(fifo.size()), 2);
    full = 1'b0;
    repeat (8) cyc();
    chk("t3_len", 32'(fifo.size()), 6);
    for (int i = 0; i < 6; i++) chk("t3_data", 32'(fifo[i]), 32'(t3e[i]));
    chk("t3_no_timeout", 32'(n_tevt), 0);
    // stalled packet terminated by EEP
    srcq[1] = '{9'h031, 9'h032};
    fifo.delete(); n_tevt = 0;
    repeat (16) cyc();
    chk("t4_early", 32'(n_tevt), 0);
    repeat (6) cyc();
    chk("t4_evt", 32'(n_tevt), 1);
    chk("t4_len", 32'(fifo.size()), 3);
    chk("t4_eep", 32'(fifo[2]), 32'h101);
    chk("t4_grant", 32'(grant), 0);
    // link loss before the first character
    srcq[0] = '{9'h041, 9'h042, 9'h043, 9'h044, 9'h100};
    fifo.delete(); n_fevt = 0; n_disc = 0;
    cyc();
    link = 3'd3;
    repeat (8) cyc();
    chk("t5_written", 32'(fifo.size()), 0);
    chk("t5_flush", 32'(n_fevt), 1);
    chk("t5_disc", 32'(n_disc), 5);
    srcq[3] = '{9'h100};
    repeat (5) cyc();
    chk("t5_nogrant", 32'(grant), 0);
    link = 3'd5;
    repeat (3) cyc();
    chk("t5_resume", 32'(fifo.size()), 1);
    // asynchronous reset mid-packet
    srcq[0] = '{9'h051, 9'h052, 9'h053, 9'h054, 9'h055, 9'h100};
    repeat (3) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_grant", 32'(grant), 0);
    chk("t6_wr", 32'(wr), 0);
    chk("t6_ready", 32'(ready), 0);
    do_reset();
    srcq[0] = '{9'h100};
    srcq[2] = '{9'h100};
    cyc();
    chk("t6_first", 32'(grant), 32'h1);
    repeat (5) cyc();
    // random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) if (srcq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
        len = $urandom_range(0, 4);
        for (int k = 0; k < len; k++) srcq[i].push_back(9'($urandom_range(0, 255)));
        if ($urandom_range(0, 5) != 0) srcq[i].push_back($urandom_range(0, 1) ? 9'h100 : 9'h101);
      end
      en = 4'($urandom);
      full = $urandom_range(0, 4) == 0;
      if (link == 3'd5 && $urandom_range(0, 80) == 0) link = 3'($urandom_range(0, 4));
      else if (link != 3'd5 && $urandom_range(0, 8) == 0) link = 3'd5;
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
